golden_nonce_arbiter: RTL and testbench
=======================================

# golden_nonce_arbiter

Collects golden-nonce reports from `NUM_CORES` free-running hashing cores and serialises them, one at a time, toward the UART report path. Cores cannot stall, so each core gets a one-entry holding slot. A round-robin scheduler drains the slots into a single registered valid/ready output. The block sits between the hash core array and the TxD message formatter in the HASHVOODOO top level.

## Interface
- `NUM_CORES`, 4: number of hashing cores; legal range 2..16.
- `ID_W`, 2: width of the core index; must equal ceil(log2(`NUM_CORES`)).
- `clk` input 1: single clock for all logic.
- `reset_n` input 1: synchronous reset, active-low; sampled on the rising edge of `clk`.
- `core_nonce_valid` input `NUM_CORES`: per-core single-cycle strobe; bit i qualifies nonce slice i.
- `core_nonce` input `NUM_CORES`*32: packed nonces; core i occupies bits [32i+31:32i].
- `out_valid` output 1: output register holds a report.
- `out_nonce` output 32: reported nonce.
- `out_core_id` output `ID_W`: index of the originating core.
- `out_ready` input 1: downstream accepts the report when `out_valid` and `out_ready` are both high.
- `drop_count` output 16: saturating count of nonces lost to a full slot.
- `pending` output `NUM_CORES`: slot-full flags, for debug and LEDs.

## Operation
- Slot i captures `core_nonce[i]` on a strobe when the slot is empty.
- Slot i also captures on a strobe in the same cycle that it is being drained into the output register. In that case the new nonce replaces the drained one with no loss.
- If a strobe hits a full slot that is not being drained, the new nonce is discarded, the old one is kept, and `drop_count` increments. `drop_count` saturates at 0xFFFF.
- If several cores drop in one cycle, `drop_count` increments by the number of drops, saturating.
- The output register is free when `out_valid` is 0, or when `out_valid` and `out_ready` are both 1 (handshake completes this cycle).
- When the output register is free and any slot is pending, the scheduler grants exactly one slot.
  - The grant goes to the first pending slot searching upward from `last_grant`+1, wrapping from `NUM_CORES`-1 to 0.
  - The granted slot's nonce and index load into `out_nonce` and `out_core_id`, and `out_valid` is set to 1.
  - The granted slot clears, unless it is refilled in the same cycle as described above.
  - `last_grant` updates to the granted index.
- With no grant, `last_grant` holds its value.
- While `out_valid` is 1 and `out_ready` is 0, `out_nonce` and `out_core_id` must hold stable.
- Scheduler states:
  - IDLE: `out_valid` is 0.
  - PRESENT: `out_valid` is 1.
  - IDLE -> PRESENT on a grant.
  - PRESENT -> PRESENT on handshake with another grant, or on no handshake.
  - PRESENT -> IDLE on handshake with no slot pending.

## Timing
- Reset values: `out_valid` 0, `out_nonce` 0, `out_core_id` 0, `drop_count` 0, `pending` all 0, `last_grant` = `NUM_CORES`-1 (so core 0 wins first).
- Reset has priority over all other activity. A reset mid-transfer discards the output and all slots without a handshake.
- Latency: strobe in cycle t -> slot full at t+1 -> `out_valid` at t+2, provided the output is free at t+1 and no other slot wins.
- Back-to-back throughput: one report per cycle while `out_ready` stays high and slots are pending.
- No combinational path from `out_ready` to `out_valid`, `out_nonce` or `out_core_id`.
- `pending` and `drop_count` are registered.

## Configuration
- `GOLDEN_DEDUP_EN` defined:
  - Each core has a last-forwarded nonce register plus a valid flag; the flag is cleared by reset.
  - A strobe whose nonce equals that core's last-forwarded nonce, with the flag set, is discarded silently. It neither fills the slot nor counts in `drop_count`.
  - The register updates when that core's slot is granted.
- `GOLDEN_DEDUP_EN` undefined: no dedup registers are built, and every strobe is handled as above.

## Test plan
- Reset, then a strobe on core 2 with nonce 0xDEADBEEF and `out_ready`=1 -> `out_valid` 2 cycles later with `out_nonce`=0xDEADBEEF and `out_core_id`=2, then `out_valid` returns to 0.
- All 4 cores strobe in one cycle after reset with `out_ready`=1 -> reports arrive in core order 0,1,2,3 on consecutive cycles, and `drop_count`=0.
- `out_ready`=0 held, core 1 strobes 0x1 then 0x2 then 0x3 -> output holds 0x1, slot holds 0x2, and `drop_count`=1. After `out_ready` rises: 0x1 is accepted, then 0x2.
- Hold `out_ready` low with `drop_count` preloaded by 65537 full-slot strobes -> `drop_count` stays at 0xFFFF.
- Assert `reset_n`=0 while `out_valid`=1 and slots are pending -> on the next edge all outputs return to reset values, and `pending`=0.
- With `GOLDEN_DEDUP_EN`: core 0 sends 0x55 twice with a handshake between -> one report only, and `drop_count`=0. Without the macro: two reports.

Source files
------------

// File: rtl/golden_nonce_if.sv
// Report handshake between golden_nonce_arbiter (master) and the TxD message formatter (slave).
interface golden_nonce_if #(
   parameter int ID_W = 2
);
   logic            out_valid;
   logic [31:0]     out_nonce;
   logic [ID_W-1:0] out_core_id;
   logic            out_ready;

   modport master (output out_valid, output out_nonce, output out_core_id, input out_ready);
   modport slave  (input out_valid, input out_nonce, input out_core_id, output out_ready);
endinterface

// File: rtl/golden_nonce_arbiter.sv
// Per-core one-entry nonce slots drained round-robin into a registered valid/ready report port.
// Define GOLDEN_DEDUP_EN to suppress repeats of each core's last forwarded nonce.
//
// state   | meaning
// IDLE    | output register empty (out_valid = 0)
// PRESENT | output register holds a report (out_valid = 1)
module golden_nonce_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ID_W      = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_CORES-1:0]    core_nonce_valid,
   input  logic [NUM_CORES*32-1:0] core_nonce,
   output logic [15:0]             drop_count,
   output logic [NUM_CORES-1:0]    pending,
   golden_nonce_if.master          rpt
);
   typedef enum logic {IDLE, PRESENT} state_t;

   localparam logic [ID_W:0] NC = (ID_W+1)'(NUM_CORES);

   state_t                 state;
   logic [31:0]            slot_nonce [NUM_CORES];
   logic [31:0]            out_nonce_q;
   logic [ID_W-1:0]        out_id_q;
   logic [ID_W-1:0]        last_grant;
   logic [ID_W-1:0]        gnt_idx;
   logic                   gnt;
   logic                   out_free;
   logic [ID_W:0]          idx;
   logic [NUM_CORES-1:0]   accept;
   logic [NUM_CORES-1:0]   hit;
   logic [NUM_CORES-1:0]   drop;
   logic [4:0]             drop_sum;
   logic [16:0]            drop_next;

   assign out_free        = (state == IDLE) || rpt.out_ready;
   assign rpt.out_valid   = (state == PRESENT);
   assign rpt.out_nonce   = out_nonce_q;
   assign rpt.out_core_id = out_id_q;

   // Walk downward so the last match is the nearest slot above last_grant.
   always_comb begin
      gnt     = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = NUM_CORES; k >= 1; k--) begin
         idx = {1'b0, last_grant} + (ID_W+1)'(k);
         if (idx >= NC) idx = idx - NC;
         if (out_free && pending[idx[ID_W-1:0]]) begin
            gnt     = 1'b1;
            gnt_idx = idx[ID_W-1:0];
         end
      end
   end

`ifdef GOLDEN_DEDUP_EN
   logic [31:0]          last_fwd [NUM_CORES];
   logic [NUM_CORES-1:0] last_fwd_v;

   always_comb begin
      accept = '0;
      for (int i = 0; i < NUM_CORES; i++)
         accept[i] = core_nonce_valid[i] &&
                     !(last_fwd_v[i] && (last_fwd[i] == core_nonce[32*i +: 32]));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_fwd_v <= '0;
      end else if (gnt) begin
         last_fwd[gnt_idx]   <= slot_nonce[gnt_idx];
         last_fwd_v[gnt_idx] <= 1'b1;
      end
   end
`else
   assign accept = core_nonce_valid;
`endif

   always_comb begin
      hit      = '0;
      drop     = '0;
      drop_sum = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         hit[i]   = gnt && (gnt_idx == ID_W'(i));
         drop[i]  = accept[i] && pending[i] && !hit[i];
         drop_sum = drop_sum + 5'(drop[i]);
      end
      drop_next = {1'b0, drop_count} + 17'(drop_sum);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending    <= '0;
         drop_count <= '0;
         for (int i = 0; i < NUM_CORES; i++) slot_nonce[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            // A refill during drain keeps the slot full with the new nonce.
            if (accept[i] && (!pending[i] || hit[i])) begin
               slot_nonce[i] <= core_nonce[32*i +: 32];
               pending[i]    <= 1'b1;
            end else if (hit[i]) begin
               pending[i] <= 1'b0;
            end
         end
         drop_count <= drop_next[16] ? 16'hFFFF : drop_next[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         out_nonce_q <= '0;
         out_id_q    <= '0;
         last_grant  <= ID_W'(NUM_CORES-1);
      end else begin
         if (gnt) begin
            out_nonce_q <= slot_nonce[gnt_idx];
            out_id_q    <= gnt_idx;
            last_grant  <= gnt_idx;
         end
         case (state)
            IDLE:    if (gnt) state <= PRESENT;
            PRESENT: if (!gnt && rpt.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Directed bench for golden_nonce_arbiter with hand-computed expectations.
module tb_golden_nonce_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  core_nonce_valid;
   logic [127:0] core_nonce;
   logic [15:0] drop_count;
   logic [3:0]  pending;
   int          tests = 0;
   int          fails = 0;

   golden_nonce_if #(.ID_W(2)) bus ();

   golden_nonce_arbiter #(.NUM_CORES(4), .ID_W(2)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .core_nonce_valid (core_nonce_valid),
      .core_nonce       (core_nonce),
      .drop_count       (drop_count),
      .pending          (pending),
      .rpt              (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n          = 1'b0;
      core_nonce_valid = '0;
      core_nonce       = '0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      bus.out_ready = 1'b1;
      do_reset();
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_nonce", bus.out_nonce, 0);
      check("rst_id",    32'(bus.out_core_id), 0);
      check("rst_drop",  32'(drop_count), 0);
      check("rst_pend",  32'(pending), 0);

      // single strobe, latency 2
      core_nonce_valid = 4'b0100;
      core_nonce[95:64] = 32'hDEADBEEF;
      tick();
      core_nonce_valid = '0;
      check("lat_t1_valid", 32'(bus.out_valid), 0);
      check("lat_t1_pend",  32'(pending), 32'h4);
      tick();
      check("lat_valid", 32'(bus.out_valid), 1);
      check("lat_nonce", bus.out_nonce, 32'hDEADBEEF);
      check("lat_id",    32'(bus.out_core_id), 2);
      check("lat_pend",  32'(pending), 0);
      tick();
      check("lat_done",  32'(bus.out_valid), 0);

      // all cores at once, drained in order back-to-back
      do_reset();
      core_nonce_valid = 4'hF;
      for (int i = 0; i < 4; i++) core_nonce[32*i +: 32] = 32'h100 + 32'(i);
      tick();
      core_nonce_valid = '0;
      check("rr_pend", 32'(pending), 32'hF);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_valid", 32'(bus.out_valid), 1);
         check("rr_id",    32'(bus.out_core_id), 32'(i));
         check("rr_nonce", bus.out_nonce, 32'h100 + 32'(i));
      end
      tick();
      check("rr_idle", 32'(bus.out_valid), 0);
      check("rr_drop", 32'(drop_count), 0);

      // stalled output: refill-on-drain, then a drop
      do_reset();
      bus.out_ready = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         core_nonce_valid = 4'b0010;
         core_nonce[63:32] = 32'(n);
         tick();
      end
      core_nonce_valid = '0;
      check("stall_nonce", bus.out_nonce, 1);
      check("stall_id",    32'(bus.out_core_id), 1);
      check("stall_pend",  32'(pending), 32'h2);
      check("stall_drop",  32'(drop_count), 1);
      tick();
      check("stall_hold",  bus.out_nonce, 1);
      bus.out_ready = 1'b1;
      tick();
      check("stall_next_v", 32'(bus.out_valid), 1);
      check("stall_next",   bus.out_nonce, 2);
      check("stall_pend2",  32'(pending), 0);
      tick();
      check("stall_idle",   32'(bus.out_valid), 0);

      // saturation: 3 drops on the second cycle, then 4 per cycle
      do_reset();
      bus.out_ready = 1'b0;
      for (int n = 0; n < 16400; n++) begin
         core_nonce_valid = 4'hF;
         for (int i = 0; i < 4; i++) core_nonce[32*i +: 32] = 32'(n) * 16 + 32'(i) + 1;
         tick();
         if (n == 2) check("multi_drop", 32'(drop_count), 7);
      end
      core_nonce_valid = '0;
      check("sat_drop",  32'(drop_count), 32'hFFFF);
      check("sat_nonce", bus.out_nonce, 1);
      check("sat_pend",  32'(pending), 32'hF);
      tick();
      check("sat_hold",  32'(drop_count), 32'hFFFF);

      // reset mid-transfer
      reset_n = 1'b0;
      tick();
      check("midrst_valid", 32'(bus.out_valid), 0);
      check("midrst_nonce", bus.out_nonce, 0);
      check("midrst_id",    32'(bus.out_core_id), 0);
      check("midrst_drop",  32'(drop_count), 0);
      check("midrst_pend",  32'(pending), 0);
      reset_n = 1'b1;

      // repeated nonce on core 0
      do_reset();
      bus.out_ready = 1'b1;
      core_nonce_valid = 4'b0001;
      core_nonce[31:0] = 32'h55;
      tick();
      core_nonce_valid = '0;
      tick();
      check("dup_first_v", 32'(bus.out_valid), 1);
      check("dup_first",   bus.out_nonce, 32'h55);
      tick();
      check("dup_gap", 32'(bus.out_valid), 0);
      core_nonce_valid = 4'b0001;
      tick();
      core_nonce_valid = '0;
      tick();
`ifdef GOLDEN_DEDUP_EN
      check("dup_second_v", 32'(bus.out_valid), 0);
      check("dup_pend",     32'(pending), 0);
`else
      check("dup_second_v", 32'(bus.out_valid), 1);
      check("dup_second",   bus.out_nonce, 32'h55);
`endif
      check("dup_drop", 32'(drop_count), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
